// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - PPU mode encoding and default scanline/frame timing constants
package ppu_pkg;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    DRAW     = 2'd3
  } PPUState;

  localparam int DEF_DOTS_PER_LINE = 456;
  localparam int DEF_OAM_DOTS      = 80;
  localparam int DEF_MAX_DRAW_DOTS = 289;
  localparam int DEF_VISIBLE_LINES = 144;
  localparam int DEF_TOTAL_LINES   = 154;

endpackage

// File: rtl/ppu_stat_irq.sv
// rtl/ppu_stat_irq.sv - STAT source select, OR and rising-edge interrupt pulse
module ppu_stat_irq
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  PPUState    mode,
  input  logic       lyc_match,
  input  logic [3:0] sel,
  output logic       irq
);

  logic stat_line;
  logic stat_prev;

  always_comb begin
    stat_line = (sel[0] && (mode == HBLANK))
             || (sel[1] && (mode == VBLANK))
             || (sel[2] && (mode == OAM_SCAN))
             || (sel[3] && lyc_match);
  end

  // A line that stays high across mode changes never re-fires.
  always_ff @(posedge clk) begin
    if (clear) begin
      stat_prev <= 1'b0;
      irq       <= 1'b0;
    end else begin
      stat_prev <= stat_line;
      irq       <= stat_line && !stat_prev;
    end
  end

endmodule

// File: rtl/ppu_timing_ctrl.sv
// rtl/ppu_timing_ctrl.sv - dot/LY counters, PPU mode sequencing and timing pulses
module ppu_timing_ctrl
  import ppu_pkg::*;
#(
  parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
  parameter int OAM_DOTS      = DEF_OAM_DOTS,
  parameter int MAX_DRAW_DOTS = DEF_MAX_DRAW_DOTS,
  parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
  parameter int TOTAL_LINES   = DEF_TOTAL_LINES
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             enable_in,
  input  logic                             draw_done_in,
  input  logic [7:0]                       lyc_in,
  input  logic [3:0]                       stat_sel_in,
  output logic [1:0]                       mode_out,
  output logic [$clog2(TOTAL_LINES)-1:0]   ly_out,
  output logic [$clog2(DOTS_PER_LINE)-1:0] dot_out,
  output logic                             line_start_out,
  output logic                             frame_start_out,
  output logic                             draw_start_out,
  output logic                             draw_overrun_out,
  output logic                             lyc_match_out,
  output logic                             stat_irq_out,
  output logic                             vblank_irq_out
);

  localparam int DOT_W = $clog2(DOTS_PER_LINE);
  localparam int LY_W  = $clog2(TOTAL_LINES);

  localparam logic [DOT_W-1:0] DOT_LAST  = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [DOT_W-1:0] DRAW_DOT  = DOT_W'(OAM_DOTS);
  localparam logic [DOT_W-1:0] DRAW_LAST = DOT_W'(OAM_DOTS + MAX_DRAW_DOTS - 1);
  localparam logic [LY_W-1:0]  LY_LAST   = LY_W'(TOTAL_LINES - 1);
  localparam logic [LY_W-1:0]  VBL_LINE  = LY_W'(VISIBLE_LINES);

  logic             running, running_n;
  PPUState          mode, mode_n;
  logic [DOT_W-1:0] dot, dot_n;
  logic [LY_W-1:0]  ly, ly_n;
  logic             line_start, line_start_n;
  logic             frame_start, frame_start_n;
  logic             draw_start, draw_start_n;
  logic             overrun, overrun_n;
  logic             vblank_irq, vblank_irq_n;
  logic             lyc_match;
  logic             stat_clear;
  logic             stat_irq;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      running     <= 1'b0;
      mode        <= HBLANK;
      dot         <= '0;
      ly          <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      draw_start  <= 1'b0;
      overrun     <= 1'b0;
      vblank_irq  <= 1'b0;
    end else begin
      running     <= running_n;
      mode        <= mode_n;
      dot         <= dot_n;
      ly          <= ly_n;
      line_start  <= line_start_n;
      frame_start <= frame_start_n;
      draw_start  <= draw_start_n;
      overrun     <= overrun_n;
      vblank_irq  <= vblank_irq_n;
    end
  end

  always_comb begin
    running_n     = running;
    mode_n        = mode;
    dot_n         = dot;
    ly_n          = ly;
    line_start_n  = 1'b0;
    frame_start_n = 1'b0;
    draw_start_n  = 1'b0;
    overrun_n     = 1'b0;
    vblank_irq_n  = 1'b0;
    if (!rst_in || !enable_in) begin
      running_n = 1'b0;
      mode_n    = HBLANK;
      dot_n     = '0;
      ly_n      = '0;
    end else if (!running) begin
      // Every enable restarts the frame from the top.
      running_n     = 1'b1;
      mode_n        = OAM_SCAN;
      dot_n         = '0;
      ly_n          = '0;
      line_start_n  = 1'b1;
      frame_start_n = 1'b1;
    end else if (dot == DOT_LAST) begin
      dot_n         = '0;
      ly_n          = (ly == LY_LAST) ? '0 : ly + 1'b1;
      mode_n        = (ly_n < VBL_LINE) ? OAM_SCAN : VBLANK;
      line_start_n  = 1'b1;
      frame_start_n = (ly == LY_LAST);
      vblank_irq_n  = (ly_n == VBL_LINE);
    end else begin
      dot_n = dot + 1'b1;
      if (ly >= VBL_LINE) begin
        mode_n = VBLANK;
      end else begin
        case (mode)
          OAM_SCAN: begin
            if (dot_n == DRAW_DOT) begin
              mode_n       = DRAW;
              draw_start_n = 1'b1;
            end
          end
          DRAW: begin
            // A done arriving on the timeout dot still counts as a clean finish.
            if (draw_done_in) begin
              mode_n = HBLANK;
            end else if (dot == DRAW_LAST) begin
              mode_n    = HBLANK;
              overrun_n = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    lyc_match        = (8'(ly) == lyc_in);
    stat_clear       = !rst_in || !enable_in || !running;
    mode_out         = mode;
    ly_out           = ly;
    dot_out          = dot;
    line_start_out   = line_start;
    frame_start_out  = frame_start;
    draw_start_out   = draw_start;
    draw_overrun_out = overrun;
    vblank_irq_out   = vblank_irq;
    lyc_match_out    = lyc_match;
    stat_irq_out     = stat_irq;
  end

  ppu_stat_irq u_stat_irq (
    .clk       (clk_in),
    .clear     (stat_clear),
    .mode      (mode),
    .lyc_match (lyc_match),
    .sel       (stat_sel_in),
    .irq       (stat_irq)
  );

endmodule

// File: doc/ppu_timing_ctrl.md
# ppu_timing_ctrl

Parametrised scanline/frame timing controller for the PPU. Owns the dot counter, the LY counter and the PPU mode (HBlank/VBlank/OAMScan/Draw). Draw length is variable and set by a done handshake from the pixel pipeline, with a forced timeout. Also produces LYC compare, STAT and VBlank interrupt pulses. Sits between the LCD-control register block and the fetcher/FIFO pipeline.

## Interface
- `DOTS_PER_LINE`, 456: dots (T-cycles) per scanline.
- `OAM_DOTS`, 80: length of OAMScan at the start of each visible line.
- `MAX_DRAW_DOTS`, 289: Draw timeout; requires `OAM_DOTS+MAX_DRAW_DOTS < DOTS_PER_LINE`.
- `VISIBLE_LINES`, 144: lines 0..VISIBLE_LINES-1 are visible.
- `TOTAL_LINES`, 154: lines per frame; the remainder are VBlank.
- `clk_in`, input, 1: dot clock.
- `rst_in`, input, 1: synchronous, active-low reset (0 = reset).
- `enable_in`, input, 1: LCD enable; 0 forces idle.
- `draw_done_in`, input, 1: one-cycle pulse from the pixel pipeline; the last pixel of the line has been pushed.
- `lyc_in`, input, 8: LY compare value.
- `stat_sel_in`, input, 4: STAT sources; [0] HBlank, [1] VBlank, [2] OAMScan, [3] LYC match.
- `mode_out`, output, 2: current `PPUState`.
- `ly_out`, output, $clog2(TOTAL_LINES): current line.
- `dot_out`, output, $clog2(DOTS_PER_LINE): dot within the line.
- `line_start_out`, output, 1: pulse when `dot_out==0` while running.
- `frame_start_out`, output, 1: pulse when `dot_out==0 && ly_out==0` while running.
- `draw_start_out`, output, 1: pulse on the first Draw cycle.
- `draw_overrun_out`, output, 1: pulse when Draw ended by timeout.
- `lyc_match_out`, output, 1: `ly_out==lyc_in`, combinational; zero-extend `ly_out` to 8 bits.
- `stat_irq_out`, output, 1: rising-edge pulse of the STAT line.
- `vblank_irq_out`, output, 1: pulse on dot 0 of line `VISIBLE_LINES`.

## Operation
- **Idle.** Entered while `rst_in==0` or `enable_in==0`.
  - dot=0, ly=0, mode=HBlank(0).
  - All pulses are 0; `stat_irq_out`=0; the STAT edge-detector history is cleared.
  - This state is also the reset value of every output.
- **Start.** The first edge with `rst_in==1 && enable_in==1` loads dot=0, ly=0, mode=OAMScan.
  - `line_start_out`=1 and `frame_start_out`=1 on that cycle.
- **Dot counter.** Each running edge increments dot.
  - At dot=DOTS_PER_LINE-1 it wraps to 0 and ly increments.
  - ly wraps from TOTAL_LINES-1 to 0.
- **Visible-line modes.**
  - OAMScan for dots 0..OAM_DOTS-1.
  - Draw from dot OAM_DOTS; `draw_start_out`=1 on that cycle.
  - HBlank from Draw exit until the wrap.
- **Draw exit.**
  - `draw_done_in`=1 while `mode_out`==Draw: next cycle is HBlank.
  - Timeout: `mode_out`==Draw at dot OAM_DOTS+MAX_DRAW_DOTS-1 with no done: next cycle is HBlank with `draw_overrun_out`=1.
  - Done and timeout in the same cycle: done wins; no overrun.
  - `draw_done_in` outside Draw is ignored.
- **VBlank.** Lines ≥ VISIBLE_LINES are VBlank for every dot; `vblank_irq_out` pulses at dot 0 of line VISIBLE_LINES.
- **STAT line.** `(sel[0]&HBlank)|(sel[1]&VBlank)|(sel[2]&OAMScan)|(sel[3]&lyc_match)`.
  - Registered with a rising-edge detect: `stat_irq_out`=1 exactly one cycle after the line goes 0→1.
  - No pulse while the line stays high across mode changes (STAT blocking).

## Timing
- The mode, dot, ly and pulse outputs are registered; they change only on `clk_in` edges.
- `stat_irq_out` latency from the STAT line rising is 1 cycle.
- `lyc_match_out` is combinational and has zero latency.
- Default frame length is DOTS_PER_LINE×TOTAL_LINES = 70224 cycles, independent of Draw length.
- Reset or disable mid-line: idle state on the next edge, with no pulses emitted on that edge.
- Re-enable always restarts at line 0, dot 0, OAMScan.

## Structure
- Shared package `ppu_pkg`:
  - `PPUState` enum (HBlank=0, VBlank=1, OAMScan=2, Draw=3).
  - Default timing constants (456, 80, 289, 144, 154).
- One sub-module, `ppu_stat_irq`: source select, STAT-line OR and rising-edge detector. Clear input is driven by idle.

## Test plan
- **Basic line:** default parameters; `draw_done_in` pulsed at dot 251 of line 0.
  - mode 2 at dots 0–79; mode 3 at dots 80–251 with `draw_start_out` at dot 80; mode 0 at dots 252–455.
  - `line_start_out` at dot 0 of line 1.
- **Draw timeout:** no `draw_done_in`.
  - Mode 3 through dot 368; mode 0 at dot 369 with `draw_overrun_out`=1 for one cycle.
- **Frame wrap:** run 70224 cycles.
  - `vblank_irq_out` at line 144 dot 0; mode 1 on lines 144–153.
  - ly wraps 153→0; `frame_start_out` on cycle 70224.
- **LYC interrupt:** `lyc_in`=5, `stat_sel_in`=4'b1000.
  - `lyc_match_out` high for all of line 5.
  - Exactly one `stat_irq_out`, at line 5 dot 1.
- **STAT blocking:** `stat_sel_in`=4'b0101 (HBlank, OAMScan).
  - One `stat_irq_out` per line, at the HBlank entry.
  - No pulse at the HBlank→OAMScan transition.
- **Reset mid-line:** `rst_in`=0 at line 10 dot 200 for 3 cycles.
  - Outputs are 0/HBlank during reset.
  - After release: mode 2, ly 0, dot 0, `frame_start_out`=1.
